// File: rtl/seq_detect_param.sv
// Serial pattern detector with run-time loadable pattern, per-bit overlap
// selection and a saturating hit counter. Match is registered (latency 1).
module seq_detect_param #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [PAT_W-1:0] pattern
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] hist_shift;
  logic [FW-1:0]    fill_inc;
  logic             hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    pattern_d  = pattern_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    match_d    = 1'b0;
    cnt_d      = cnt_q;
    hit        = 1'b0;
    hist_shift = {hist_q[PAT_W-2:0], in};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);

    // A load flushes history and swallows any data bit arriving with it.
    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hit     = (fill_inc == FILL_FULL) && (hist_shift == pattern_q);
      hist_d  = hist_shift;
      fill_d  = fill_inc;
      match_d = hit;
      if (hit && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= PAT_RST;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign pattern     = pattern_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a default 3-bit/8-bit instance and a 2-bit
// pattern / 2-bit counter instance share the serial stimulus.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [2:0] pat_in = 3'b000;
  logic [1:0] pat_in2 = 2'b11;
  logic       cnt_clr = 1'b0;

  logic       match1, match2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  logic [2:0] pat1;
  logic [1:0] pat2;

  int checks = 0;
  int failures = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(3), .PAT_RST(3'b101), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .match(match1), .match_count(cnt1), .pattern(pat1)
  );

  seq_detect_param #(.PAT_W(2), .PAT_RST(2'b11), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in2), .cnt_clr(cnt_clr),
    .match(match2), .match_count(cnt2), .pattern(pat2)
  );

  // Model: remember the valid bits seen since the last flush (at most the
  // pattern length, oldest first) and compare them with the pattern.
  int         q1[$];
  int         q2[$];
  logic [7:0] epat1, epat2;
  int         ecnt1, ecnt2;
  bit         em1, em2;

  function automatic bit bits_equal(input int q[$], input int plen, input logic [7:0] p);
    if (q.size() != plen) return 0;
    for (int i = 0; i < plen; i++)
      if (q[i] != int'(p[plen-1-i])) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      epat1 = 8'b101; epat2 = 8'b11;
      q1.delete(); q2.delete();
      em1 = 0; em2 = 0; ecnt1 = 0; ecnt2 = 0;
    end else begin
      em1 = 0; em2 = 0;
      if (pat_load) begin
        epat1 = {5'b0, pat_in}; epat2 = {6'b0, pat_in2};
        q1.delete(); q2.delete();
      end else if (in_valid) begin
        q1.push_back(int'(din)); if (q1.size() > 3) void'(q1.pop_front());
        q2.push_back(int'(din)); if (q2.size() > 2) void'(q2.pop_front());
        em1 = bits_equal(q1, 3, epat1);
        em2 = bits_equal(q2, 2, epat2);
        if (em1 && !overlap) q1.delete();
        if (em2 && !overlap) q2.delete();
      end
      if (cnt_clr) begin
        ecnt1 = 0; ecnt2 = 0;
      end else begin
        if (em1 && ecnt1 < 255) ecnt1++;
        if (em2 && ecnt2 < 3) ecnt2++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (armed) begin
      check("model_match1", int'(match1), int'(em1));
      check("model_cnt1", int'(cnt1), ecnt1);
      check("model_pat1", int'(pat1), int'(epat1));
      check("model_match2", int'(match2), int'(em2));
      check("model_cnt2", int'(cnt2), ecnt2);
      check("model_pat2", int'(pat2), int'(epat2));
    end
  end

  task automatic drive(input logic b, input logic v, input logic ld, input logic clr);
    @(negedge clk);
    reset = 1'b0; din = b; in_valid = v; pat_load = ld; cnt_clr = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic bit_in(input logic b);
    drive(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    do_reset();
    armed = 1;
    check("rst_match", int'(match1), 0);
    check("rst_cnt", int'(cnt1), 0);
    check("rst_pat", int'(pat1), 3'b101);
    check("rst_pat2", int'(pat2), 2'b11);

    // 1: overlapping 10101
    overlap = 1'b1;
    bit_in(1); bit_in(0); bit_in(1);
    check("t1_hit3", int'(match1), 1);
    bit_in(0);
    check("t1_nohit4", int'(match1), 0);
    bit_in(1);
    check("t1_hit5", int'(match1), 1);
    check("t1_cnt", int'(cnt1), 2);

    // 2: non-overlapping
    do_reset();
    overlap = 1'b0;
    bit_in(1); bit_in(0); bit_in(1);
    check("t2_hit3", int'(match1), 1);
    bit_in(0); bit_in(1);
    check("t2_nohit5", int'(match1), 0);
    check("t2_cnt", int'(cnt1), 1);
    do_reset();
    bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0); bit_in(1);
    check("t2b_hit6", int'(match1), 1);
    check("t2b_cnt", int'(cnt1), 2);

    // 3: pattern load drops the coincident bit
    do_reset();
    overlap = 1'b1;
    bit_in(1); bit_in(0);
    pat_in = 3'b110;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_pat", int'(pat1), 3'b110);
    check("t3_ldmatch", int'(match1), 0);
    bit_in(1); bit_in(1);
    check("t3_nohit2", int'(match1), 0);
    bit_in(0);
    check("t3_hit", int'(match1), 1);
    pat_in = 3'b000;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    bit_in(0);
    check("t3_zero1", int'(match1), 0);
    bit_in(0);
    check("t3_zero2", int'(match1), 0);
    bit_in(0);
    check("t3_zero3", int'(match1), 1);

    // 4: gapped input holds history
    do_reset();
    bit_in(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_gap", int'(match1), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_gap2", int'(match1), 0);
    bit_in(1);
    check("t4_hit", int'(match1), 1);

    // 5: saturating 2-bit counter on pattern 11
    do_reset();
    overlap = 1'b1;
    bit_in(1);
    check("t5_first", int'(match2), 0);
    bit_in(1); check("t5_c1", int'(cnt2), 1);
    bit_in(1); check("t5_c2", int'(cnt2), 2);
    bit_in(1); check("t5_c3", int'(cnt2), 3);
    bit_in(1); check("t5_c4", int'(cnt2), 3);
    bit_in(1); check("t5_c5", int'(cnt2), 3);
    bit_in(1); check("t5_c6", int'(cnt2), 3);
    check("t5_m", int'(match2), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_clr_m", int'(match2), 1);
    check("t5_clr_c", int'(cnt2), 0);

    // 6: reset mid-stream loses the partial sequence
    do_reset();
    bit_in(1); bit_in(0);
    do_reset();
    check("t6_pat", int'(pat1), 3'b101);
    check("t6_m", int'(match1), 0);
    check("t6_c", int'(cnt1), 0);
    bit_in(1);
    check("t6_nohit", int'(match1), 0);
    bit_in(1); bit_in(0); bit_in(1);
    check("t6_hit", int'(match1), 1);

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
